fir_coef_loader: RTL and testbench

FIR_COEF_LOADER -- requirements
Module: fir_coef_loader

---
 rtl/fir_coef_loader.sv | 176 +++++++++++++++++
 tb/tb_fir_coef_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_coef_loader.sv
// fir_coef_loader
//   Reloads the coefficient registers of a shift-in FIR tap chain from a
//   valid/ready beat stream. While loading, the chain's sample strobe is
//   gated off. After loading, the chain can optionally be flushed with zero
//   samples so that no stale data mixes with the new coefficients.
//
//   Optional feature macro: FIR_LOADER_FLUSH_EN
//     defined   : LOAD -> FLUSH (2*NTAPS+2 zero-sample strobes) -> DONE
//     undefined : LOAD -> DONE, o_zero tied low, no flush counter
//
// Parameters
//   NTAPS  number of taps in the chain (>= 2)
//   TW     coefficient width
//
// Ports
//   i_clk, i_reset_n   clock, asynchronous active-low reset
//   i_load_start       1-cycle reload request (honoured in IDLE only)
//   i_abort            abandon a reload in LOAD/FLUSH (sets o_err)
//   s_coef_*           coefficient beat stream; first beat = last tap
//   i_ce / o_ce        upstream sample strobe / gated strobe to the chain
//   o_zero             force the chain input sample to zero (FLUSH)
//   o_tap_wr, o_tap    registered shift-in to the tap chain
//   o_busy             reload in progress (LOAD or FLUSH)
//   o_done             one-cycle completion pulse
//   o_err              sticky error, cleared by the next accepted start
module fir_coef_loader #(
  parameter int unsigned NTAPS = 16,
  parameter int unsigned TW    = 16
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_load_start,
  input  logic          i_abort,
  input  logic          s_coef_valid,
  input  logic [TW-1:0] s_coef_data,
  input  logic          s_coef_last,
  output logic          s_coef_ready,
  input  logic          i_ce,
  output logic          o_ce,
  output logic          o_zero,
  output logic          o_tap_wr,
  output logic [TW-1:0] o_tap,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  localparam int unsigned CW = $clog2(NTAPS + 1);
  localparam logic [CW-1:0] NTAPS_C  = CW'(NTAPS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NTAPS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
`ifdef FIR_LOADER_FLUSH_EN
  localparam logic [1:0] S_FLUSH = 2'd2;
`endif
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [CW-1:0] count;
  logic          accept;
  logic          load_end;
  logic          load_bad;
  logic          in_work;
  logic          start_ok;

`ifdef FIR_LOADER_FLUSH_EN
  localparam int unsigned FW = $clog2(2 * NTAPS + 2);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * NTAPS + 1);
  logic [FW-1:0] flush_cnt;
`endif

  // Abort takes priority over a beat presented in the same cycle.
  assign s_coef_ready = (state == S_LOAD) && (count < NTAPS_C) && !i_abort;
  assign accept       = s_coef_ready && s_coef_valid;
  // LOAD ends on the beat flagged last or on the NTAPS-th beat, whichever first.
  assign load_end     = accept && (s_coef_last || (count == LAST_IDX));
  // Error when the last flag and the NTAPS-th beat do not coincide.
  assign load_bad     = load_end && (s_coef_last != (count == LAST_IDX));
  assign start_ok     = (state == S_IDLE) && i_load_start;
`ifdef FIR_LOADER_FLUSH_EN
  assign in_work      = (state == S_LOAD) || (state == S_FLUSH);
`else
  assign in_work      = (state == S_LOAD);
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (i_load_start) state_nx = S_LOAD;
      end
      S_LOAD: begin
        if (i_abort) begin
          state_nx = S_IDLE;
        end else if (load_end) begin
`ifdef FIR_LOADER_FLUSH_EN
          state_nx = S_FLUSH;
`else
          state_nx = S_DONE;
`endif
        end
      end
`ifdef FIR_LOADER_FLUSH_EN
      S_FLUSH: begin
        if (i_abort) begin
          state_nx = S_IDLE;
        end else if (flush_cnt == FLUSH_LAST) begin
          state_nx = S_DONE;
        end
      end
`endif
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= S_IDLE;
      count    <= '0;
      o_err    <= 1'b0;
      o_tap_wr <= 1'b0;
      o_tap    <= '0;
    end else begin
      state    <= state_nx;
      o_tap_wr <= accept;
      if (accept) o_tap <= s_coef_data;

      if (start_ok) begin
        count <= '0;
      end else if (accept) begin
        count <= count + 1'b1;
      end

      if (start_ok) begin
        o_err <= 1'b0;
      end else if ((in_work && i_abort) || load_bad) begin
        o_err <= 1'b1;
      end
    end
  end

`ifdef FIR_LOADER_FLUSH_EN
  // Counts cycles spent in FLUSH; held at zero everywhere else.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      flush_cnt <= '0;
    end else if (state == S_FLUSH) begin
      flush_cnt <= flush_cnt + 1'b1;
    end else begin
      flush_cnt <= '0;
    end
  end
`endif

  always_comb begin
    o_ce   = 1'b0;
    o_zero = 1'b0;
    case (state)
      S_IDLE: o_ce = i_ce;
`ifdef FIR_LOADER_FLUSH_EN
      S_FLUSH: begin
        o_ce   = 1'b1;
        o_zero = 1'b1;
      end
`endif
      default: o_ce = 1'b0;
    endcase
  end

  assign o_busy = in_work;
  assign o_done = (state == S_DONE);

endmodule

// File: tb/tb_fir_coef_loader.sv
// Bench for fir_coef_loader with NTAPS=4, TW=16: table-driven reload
// scenarios, hand-written reset cases and a randomized soak, all checked
// every cycle against a phase/countdown reference model.
module tb_fir_coef_loader;

  localparam int N = 4;
`ifdef FIR_LOADER_FLUSH_EN
  localparam int FLUSH_LEN = 2 * N + 2;
`else
  localparam int FLUSH_LEN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_load_start, i_abort, s_coef_valid, s_coef_last, i_ce;
  logic [15:0] s_coef_data;
  logic        s_coef_ready, o_ce, o_zero, o_tap_wr, o_busy, o_done, o_err;
  logic [15:0] o_tap;

  always #5 clk = ~clk;

  fir_coef_loader #(.NTAPS(N), .TW(16)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_load_start(i_load_start),
    .i_abort(i_abort), .s_coef_valid(s_coef_valid), .s_coef_data(s_coef_data),
    .s_coef_last(s_coef_last), .s_coef_ready(s_coef_ready), .i_ce(i_ce),
    .o_ce(o_ce), .o_zero(o_zero), .o_tap_wr(o_tap_wr), .o_tap(o_tap),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: "loading" flag with accepted-beat tally, a flush
  // countdown, a one-cycle done marker, and the pending tap write.
  bit          m_load;
  int          m_acc;
  int          m_flush;
  bit          m_done;
  bit          m_err;
  bit          m_wr;
  logic [15:0] m_tap;

  logic [15:0] taps_seen[$];
  int          dones;

  typedef struct {
    int last_at;   // beat number carrying last, 0 = never
    int abort_at;  // abort while this beat number is presented, 0 = never
    int hold;      // cycles valid is held after the start pulse
    int exp_writes;
    bit exp_err;
    int exp_done;
  } scen_t;

  scen_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_load = 0; m_acc = 0; m_flush = 0; m_done = 0; m_err = 0; m_wr = 0; m_tap = '0;
  endfunction

  task automatic compare_outputs();
    chk("ready",  s_coef_ready, m_load && !i_abort);
    chk("o_ce",   o_ce, m_load ? 1'b0 : (m_flush > 0 ? 1'b1 : (m_done ? 1'b0 : i_ce)));
    chk("o_zero", o_zero, m_flush > 0);
    chk("o_busy", o_busy, m_load || m_flush > 0);
    chk("o_done", o_done, m_done);
    chk("o_tap_wr", o_tap_wr, m_wr);
    if (m_wr) chk("o_tap", o_tap, m_tap);
    chk("o_err",  o_err, m_err);
  endtask

  task automatic model_edge();
    bit acc;
    bit was_idle;
    acc      = m_load && s_coef_valid && !i_abort;
    was_idle = !m_load && m_flush == 0 && !m_done;
    m_wr = acc;
    if (acc) m_tap = s_coef_data;
    if (was_idle) begin
      if (i_load_start) begin m_load = 1; m_acc = 0; m_err = 0; end
    end else if (m_load) begin
      if (i_abort) begin
        m_load = 0; m_err = 1;
      end else if (acc) begin
        m_acc++;
        if (s_coef_last || m_acc == N) begin
          if (s_coef_last != (m_acc == N)) m_err = 1;
          m_load = 0;
          if (FLUSH_LEN > 0) m_flush = FLUSH_LEN;
          else m_done = 1;
        end
      end
    end else if (m_flush > 0) begin
      if (i_abort) begin
        m_flush = 0; m_err = 1;
      end else begin
        m_flush--;
        if (m_flush == 0) m_done = 1;
      end
    end else begin
      m_done = 0;
    end
  endtask

  task automatic step(input bit st, input bit ab, input bit v, input logic [15:0] d, input bit l);
    @(negedge clk);
    i_load_start = st; i_abort = ab; s_coef_valid = v; s_coef_data = d; s_coef_last = l;
    i_ce = 1'($urandom_range(0, 1));
    #1;
    compare_outputs();
    if (o_tap_wr) taps_seen.push_back(o_tap);
    if (o_done) dones++;
    model_edge();
  endtask

  task automatic run_scenario(input scen_t s, input int idx);
    int nb;
    bit v, ab;
    taps_seen.delete();
    dones = 0;
    step(1, 0, 0, 16'h0, 0);
    for (int c = 0; c < 40; c++) begin
      nb = m_acc + 1;
      v  = c < s.hold;
      ab = v && m_load && (nb == s.abort_at);
      step(0, ab, v, 16'(nb), v && (nb == s.last_at));
    end
    chk($sformatf("s%0d_writes", idx), taps_seen.size(), s.exp_writes);
    for (int i = 0; i < taps_seen.size(); i++)
      chk($sformatf("s%0d_tap%0d", idx, i), taps_seen[i], i + 1);
    chk($sformatf("s%0d_err", idx), o_err, s.exp_err);
    chk($sformatf("s%0d_dones", idx), dones, s.exp_done);
    chk($sformatf("s%0d_idle", idx), o_busy, 1'b0);
  endtask

  task automatic async_reset_check(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_busy"},  o_busy, 1'b0);
    chk({tag, "_zero"},  o_zero, 1'b0);
    chk({tag, "_err"},   o_err, 1'b0);
    chk({tag, "_done"},  o_done, 1'b0);
    chk({tag, "_ready"}, s_coef_ready, 1'b0);
    chk({tag, "_tapwr"}, o_tap_wr, 1'b0);
    chk({tag, "_tap"},   o_tap, 16'h0);
    chk({tag, "_ce"},    o_ce, i_ce);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{last_at: 4, abort_at: 0, hold: 4, exp_writes: 4, exp_err: 0, exp_done: 1};
    tbl[1] = '{last_at: 2, abort_at: 0, hold: 6, exp_writes: 2, exp_err: 1, exp_done: 1};
    tbl[2] = '{last_at: 0, abort_at: 0, hold: 6, exp_writes: 4, exp_err: 1, exp_done: 1};
    tbl[3] = '{last_at: 4, abort_at: 3, hold: 6, exp_writes: 2, exp_err: 1, exp_done: 0};
    tbl[4] = '{last_at: 1, abort_at: 0, hold: 1, exp_writes: 1, exp_err: 1, exp_done: 1};

    rst_n = 1'b0;
    i_load_start = 0; i_abort = 0; s_coef_valid = 0; s_coef_data = '0; s_coef_last = 0;
    i_ce = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ce_hi", o_ce, 1'b1);
    i_ce = 1'b0;
    #1;
    chk("rst_ce_lo", o_ce, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_tap", o_tap, 16'h0);
    chk("rst_tapwr", o_tap_wr, 1'b0);
    chk("rst_ready", s_coef_ready, 1'b0);
    chk("rst_err", o_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_scenario(tbl[i], i);

    // Reset mid-LOAD: partial load discarded, no done, no error.
    dones = 0;
    step(1, 0, 0, 16'h0, 0);
    step(0, 0, 1, 16'h00a1, 0);
    step(0, 0, 1, 16'h00a2, 0);
    async_reset_check("rst_load");
    for (int c = 0; c < 15; c++) step(0, 0, 0, 16'h0, 0);
    chk("rst_load_nodone", dones, 0);

    // Reset a few cycles after LOAD completes (inside FLUSH when enabled).
    step(1, 0, 0, 16'h0, 0);
    for (int b = 1; b <= N; b++) step(0, 0, 1, 16'(b), b == N);
    for (int c = 0; c < 4; c++) step(0, 0, 0, 16'h0, 0);
    async_reset_check("rst_flush");

    // Randomized soak, every cycle compared with the model.
    for (int c = 0; c < 600; c++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 2) != 0, 16'($urandom), $urandom_range(0, 3) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
